// File: rtl/comm_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | comm_pkg : message codes, frame constants and frame builder shared by     |
// |            the link transmitter and receiver.                            |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package comm_pkg;

    typedef enum logic [2:0] {
        MSG_NONE      = 3'd0,
        BALL          = 3'd1,
        MISS          = 3'd2,
        ARE_YOU_THERE = 3'd3,
        I_AM_HERE     = 3'd4,
        I_LOST        = 3'd5,
        NEW_GAME      = 3'd6,
        MSG_RSVD      = 3'd7
    } msg_type_t;

    localparam logic [3:0] SYNC_NIBBLE   = 4'hA;
    localparam int         FRAME_BYTES   = 5;
    localparam int         FRAME_BITS    = 8 * FRAME_BYTES;
    localparam logic [2:0] LAST_BYTE_IDX = 3'(FRAME_BYTES - 1);

    typedef enum logic [1:0] {
        BIT_IDLE  = 2'd0,
        BIT_START = 2'd1,
        BIT_DATA  = 2'd2,
        BIT_STOP  = 2'd3
    } bit_state_t;

    typedef enum logic [1:0] {
        FRM_IDLE = 2'd0,
        FRM_SEND = 2'd1,
        FRM_DONE = 2'd2
    } frame_state_t;

    function automatic logic is_valid_type(input logic [2:0] code);
        return (code != 3'd0) && (code != 3'd7);
    endfunction

    // Byte 0 sits in the low bits so the frame can be shifted out byte by byte.
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic [2:0] code,
        input logic [8:0] ball_y,
        input logic [3:0] velocity_x,
        input logic [3:0] velocity_y,
        input logic       sign_y
    );
        logic [7:0] b0, b1, b2, b3;
        b0 = {SYNC_NIBBLE, 1'b0, code};
        if (code == BALL) begin
            b1 = ball_y[7:0];
            b2 = {velocity_x, velocity_y};
            b3 = {6'b0, ball_y[8], sign_y};
        end else begin
            b1 = 8'h00;
            b2 = 8'h00;
            b3 = 8'h00;
        end
        return {b0 ^ b1 ^ b2 ^ b3, b3, b2, b1, b0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/comm_transmitter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | comm_transmitter_if : message request handshake between game logic and   |
// |                       the link transmitter.                              |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
interface comm_transmitter_if;
    import comm_pkg::*;

    logic       send;
    msg_type_t  msg_type;
    logic [8:0] ball_y;
    logic [3:0] velocity_x;
    logic [3:0] velocity_y;
    logic       sign_y;
    logic       ready;
    logic       done;

    modport master (
        output send, msg_type, ball_y, velocity_x, velocity_y, sign_y,
        input  ready, done
    );

    modport slave (
        input  send, msg_type, ball_y, velocity_x, velocity_y, sign_y,
        output ready, done
    );
endinterface
`default_nettype wire

// File: rtl/comm_uart_tx_byte.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | comm_uart_tx_byte : 8N1 byte serializer, LSB first, registered line.     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module comm_uart_tx_byte
    import comm_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clock,
    input  logic       reset_L,
    input  logic [7:0] data_byte,
    input  logic       start,
    output logic       busy,
    output logic       byte_done,
    output logic       tx
);
    localparam int                 TIMER_W   = $clog2(CLKS_PER_BIT);
    localparam logic [TIMER_W-1:0] LAST_TICK = TIMER_W'(CLKS_PER_BIT - 1);

    bit_state_t         r_state, w_state_n;
    logic [TIMER_W-1:0] r_timer, w_timer_n;
    logic [2:0]         r_bit_cnt, w_bit_cnt_n;
    logic [7:0]         r_shift, w_shift_n;
    logic               r_tx, w_tx_n;
    logic               w_bit_end;

    assign w_bit_end = (r_timer == LAST_TICK);
    assign busy      = (r_state != BIT_IDLE);
    // Asserted in the last stop-bit cycle so a following byte starts with no gap.
    assign byte_done = (r_state == BIT_STOP) && w_bit_end;
    assign tx        = r_tx;

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            r_state   <= BIT_IDLE;
            r_timer   <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_n;
            r_timer   <= w_timer_n;
            r_bit_cnt <= w_bit_cnt_n;
            r_shift   <= w_shift_n;
            r_tx      <= w_tx_n;
        end
    end

    always_comb begin
        w_state_n   = r_state;
        w_timer_n   = r_timer + TIMER_W'(1);
        w_bit_cnt_n = r_bit_cnt;
        w_shift_n   = r_shift;
        w_tx_n      = r_tx;
        case (r_state)
            BIT_IDLE: begin
                w_timer_n = '0;
                if (start) begin
                    w_state_n = BIT_START;
                    w_shift_n = data_byte;
                    w_tx_n    = 1'b0;
                end
            end
            BIT_START: begin
                if (w_bit_end) begin
                    w_state_n   = BIT_DATA;
                    w_timer_n   = '0;
                    w_bit_cnt_n = '0;
                    w_tx_n      = r_shift[0];
                end
            end
            BIT_DATA: begin
                if (w_bit_end) begin
                    w_timer_n = '0;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_n = BIT_STOP;
                        w_tx_n    = 1'b1;
                    end else begin
                        w_bit_cnt_n = r_bit_cnt + 3'd1;
                        w_shift_n   = r_shift >> 1;
                        w_tx_n      = r_shift[1];
                    end
                end
            end
            BIT_STOP: begin
                if (w_bit_end) begin
                    w_timer_n = '0;
                    if (start) begin
                        w_state_n = BIT_START;
                        w_shift_n = data_byte;
                        w_tx_n    = 1'b0;
                    end else begin
                        w_state_n = BIT_IDLE;
                    end
                end
            end
            default: w_state_n = BIT_IDLE;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/comm_transmitter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | comm_transmitter : builds the 5-byte game frame and sends it over 8N1.   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module comm_transmitter
    import comm_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic               clock,
    input  logic               reset_L,
    comm_transmitter_if.slave  bus,
    output logic               tx
);
    frame_state_t          r_state, w_state_n;
    logic [2:0]            r_idx, w_idx_n;
    logic [FRAME_BITS-1:0] r_frame, w_frame_n, w_frame_in;
    logic                  w_ready, w_accept, w_more;
    logic                  w_byte_start, w_byte_done, w_byte_busy;
    logic [7:0]            w_byte_data;

    assign w_frame_in = build_frame(bus.msg_type, bus.ball_y, bus.velocity_x,
                                    bus.velocity_y, bus.sign_y);
    assign w_ready    = (r_state == FRM_IDLE) && !w_byte_busy;
    assign w_accept   = bus.send && w_ready && is_valid_type(bus.msg_type);
    assign w_more     = (r_state == FRM_SEND) && w_byte_done && (r_idx < LAST_BYTE_IDX);
    assign bus.ready  = w_ready;
    assign bus.done   = (r_state == FRM_DONE);

    // Byte 0 goes straight from the inputs so its start bit follows acceptance;
    // later bytes come from the captured frame, which shifts down one byte each time.
    assign w_byte_start = w_accept || w_more;
    assign w_byte_data  = w_accept ? w_frame_in[7:0] : r_frame[15:8];

    comm_uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_byte (
        .clock     (clock),
        .reset_L   (reset_L),
        .data_byte (w_byte_data),
        .start     (w_byte_start),
        .busy      (w_byte_busy),
        .byte_done (w_byte_done),
        .tx        (tx)
    );

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            r_state <= FRM_IDLE;
            r_idx   <= '0;
            r_frame <= '0;
        end else begin
            r_state <= w_state_n;
            r_idx   <= w_idx_n;
            r_frame <= w_frame_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_idx_n   = r_idx;
        w_frame_n = r_frame;
        case (r_state)
            FRM_IDLE: begin
                if (w_accept) begin
                    w_state_n = FRM_SEND;
                    w_idx_n   = '0;
                    w_frame_n = w_frame_in;
                end
            end
            FRM_SEND: begin
                if (w_byte_done) begin
                    if (r_idx < LAST_BYTE_IDX) begin
                        w_idx_n   = r_idx + 3'd1;
                        w_frame_n = r_frame >> 8;
                    end else begin
                        w_state_n = FRM_DONE;
                    end
                end
            end
            FRM_DONE: w_state_n = FRM_IDLE;
            default:  w_state_n = FRM_IDLE;
        endcase
    end
endmodule
`default_nettype wire

// File: tb/tb_comm_transmitter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_comm_transmitter : frame/timing bench for comm_transmitter.           |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_comm_transmitter;
    import comm_pkg::*;

    localparam int CPB       = 8;
    localparam int FRAME_CYC = 50 * CPB;
    localparam int LOG_LEN   = 2 * FRAME_CYC + 64;

    logic clock   = 1'b0;
    logic reset_L = 1'b0;
    logic tx;

    comm_transmitter_if bus();

    comm_transmitter #(.CLKS_PER_BIT(CPB)) dut (
        .clock   (clock),
        .reset_L (reset_L),
        .bus     (bus),
        .tx      (tx)
    );

    always #5 clock = ~clock;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] exp_q [$];
    logic       tx_log    [0:LOG_LEN];
    logic       done_log  [0:LOG_LEN];
    logic       ready_log [0:LOG_LEN];

    // Line level of each of the 10 bit slots of byte j, sampled in the first
    // or last cycle of the slot; index 1 is the first cycle after acceptance.
    function automatic logic [9:0] bits_at(input int base, input int j, input bit last);
        logic [9:0] w;
        for (int k = 0; k < 10; k++)
            w[k] = tx_log[base + 10*CPB*j + CPB*k + (last ? CPB : 1)];
        return w;
    endfunction

    task automatic drive_msg(input msg_type_t t, input logic [8:0] y,
                             input logic [3:0] vx, input logic [3:0] vy, input logic sy);
        bus.msg_type   = t;
        bus.ball_y     = y;
        bus.velocity_x = vx;
        bus.velocity_y = vy;
        bus.sign_y     = sy;
    endtask

    task automatic send_one(input msg_type_t t, input logic [8:0] y,
                            input logic [3:0] vx, input logic [3:0] vy, input logic sy);
        @(negedge clock);
        drive_msg(t, y, vx, vy, sy);
        bus.send = 1'b1;
        @(posedge clock);
        #1 bus.send = 1'b0;
    endtask

    task automatic push_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                              input logic [7:0] b3, input logic [7:0] b4);
        exp_q.push_back(b0); exp_q.push_back(b1); exp_q.push_back(b2);
        exp_q.push_back(b3); exp_q.push_back(b4);
    endtask

    task automatic capture(input int n);
        for (int i = 1; i <= n; i++) begin
            @(negedge clock);
            tx_log[i]    = tx;
            done_log[i]  = bus.done;
            ready_log[i] = bus.ready;
        end
    endtask

    task automatic test_reset();
        bus.send = 1'b0;
        drive_msg(MSG_NONE, 9'h0, 4'h0, 4'h0, 1'b0);
        reset_L = 1'b0;
        repeat (3) @(negedge clock);
        n_checks++; if (tx !== 1'b1)       $display("FAIL reset_tx: got %b expected 1", tx);        else n_pass++;
        n_checks++; if (bus.ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", bus.ready); else n_pass++;
        n_checks++; if (bus.done !== 1'b0)  $display("FAIL reset_done: got %b expected 0", bus.done);  else n_pass++;
        reset_L = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_ball();
        int ndone;
        logic [7:0] e;
        logic [9:0] of, ol;
        push_frame(8'hA1, 8'h2C, 8'h53, 8'h03, 8'hDD);
        send_one(BALL, 9'h12C, 4'd5, 4'd3, 1'b1);
        capture(FRAME_CYC + 4);
        for (int j = 0; j < 5; j++) begin
            e = exp_q.pop_front();
            of = bits_at(0, j, 1'b0);
            ol = bits_at(0, j, 1'b1);
            n_checks++;
            if (of !== {1'b1, e, 1'b0} || ol !== {1'b1, e, 1'b0})
                $display("FAIL ball_byte%0d: got first=%b last=%b expected %b", j, of, ol, {1'b1, e, 1'b0});
            else n_pass++;
        end
        ndone = 0;
        for (int i = 1; i <= FRAME_CYC + 4; i++) if (done_log[i] === 1'b1) ndone++;
        n_checks++;
        if (done_log[FRAME_CYC+1] !== 1'b1 || ndone != 1)
            $display("FAIL ball_done: got done@%0d=%b pulses=%0d expected 1 and 1", FRAME_CYC+1, done_log[FRAME_CYC+1], ndone);
        else n_pass++;
        n_checks++;
        if (ready_log[1] !== 1'b0 || ready_log[FRAME_CYC+1] !== 1'b0 || ready_log[FRAME_CYC+2] !== 1'b1)
            $display("FAIL ball_ready: got %b%b%b expected 001", ready_log[1], ready_log[FRAME_CYC+1], ready_log[FRAME_CYC+2]);
        else n_pass++;
        n_checks++;
        if ({tx_log[FRAME_CYC+1], tx_log[FRAME_CYC+2], tx_log[FRAME_CYC+3], tx_log[FRAME_CYC+4]} !== 4'b1111)
            $display("FAIL ball_idle_after: got %b%b%b%b expected 1111", tx_log[FRAME_CYC+1], tx_log[FRAME_CYC+2], tx_log[FRAME_CYC+3], tx_log[FRAME_CYC+4]);
        else n_pass++;
    endtask

    task automatic test_new_game();
        logic [7:0] e;
        logic [9:0] of, ol;
        push_frame(8'hA6, 8'h00, 8'h00, 8'h00, 8'hA6);
        send_one(NEW_GAME, 9'h1FF, 4'hF, 4'hF, 1'b1);
        capture(FRAME_CYC + 4);
        for (int j = 0; j < 5; j++) begin
            e = exp_q.pop_front();
            of = bits_at(0, j, 1'b0);
            ol = bits_at(0, j, 1'b1);
            n_checks++;
            if (of !== {1'b1, e, 1'b0} || ol !== {1'b1, e, 1'b0})
                $display("FAIL newgame_byte%0d: got first=%b last=%b expected %b", j, of, ol, {1'b1, e, 1'b0});
            else n_pass++;
        end
    endtask

    task automatic test_invalid();
        msg_type_t bad_types [2];
        int bad;
        bad_types[0] = MSG_NONE;
        bad_types[1] = MSG_RSVD;
        for (int t = 0; t < 2; t++) begin
            @(negedge clock);
            drive_msg(bad_types[t], 9'h1FF, 4'hF, 4'hF, 1'b1);
            bus.send = 1'b1;
            bad = 0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clock);
                if (tx !== 1'b1 || bus.ready !== 1'b1 || bus.done !== 1'b0) bad++;
            end
            bus.send = 1'b0;
            n_checks++;
            if (bad != 0) $display("FAIL invalid_type%0d: got %0d bad cycles expected 0", bad_types[t], bad);
            else n_pass++;
        end
    endtask

    task automatic test_mid_frame();
        int ndone, nbusy;
        logic [7:0] e;
        logic [9:0] of, ol;
        push_frame(8'hA1, 8'h2C, 8'h53, 8'h03, 8'hDD);
        send_one(BALL, 9'h12C, 4'd5, 4'd3, 1'b1);
        fork
            capture(FRAME_CYC + 10*CPB);
            begin
                repeat (3*CPB) @(negedge clock);
                drive_msg(NEW_GAME, 9'h0F0, 4'hA, 4'hC, 1'b0);
                bus.send = 1'b1;
                repeat (12*CPB) @(negedge clock);
                drive_msg(MISS, 9'h155, 4'h1, 4'h2, 1'b0);
                repeat (12*CPB) @(negedge clock);
                bus.send = 1'b0;
            end
        join
        for (int j = 0; j < 5; j++) begin
            e = exp_q.pop_front();
            of = bits_at(0, j, 1'b0);
            ol = bits_at(0, j, 1'b1);
            n_checks++;
            if (of !== {1'b1, e, 1'b0} || ol !== {1'b1, e, 1'b0})
                $display("FAIL midframe_byte%0d: got first=%b last=%b expected %b", j, of, ol, {1'b1, e, 1'b0});
            else n_pass++;
        end
        ndone = 0;
        nbusy = 0;
        for (int i = 1; i <= FRAME_CYC + 10*CPB; i++) if (done_log[i] === 1'b1) ndone++;
        for (int i = FRAME_CYC + 1; i <= FRAME_CYC + 10*CPB; i++) if (tx_log[i] !== 1'b1) nbusy++;
        n_checks++;
        if (ndone != 1 || nbusy != 0 || ready_log[FRAME_CYC + 10*CPB] !== 1'b1)
            $display("FAIL midframe_no_second: got done=%0d low_cycles=%0d ready=%b expected 1 0 1", ndone, nbusy, ready_log[FRAME_CYC + 10*CPB]);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int ndone, nbusy;
        logic [7:0] e;
        logic [9:0] of, ol;
        push_frame(8'hA3, 8'h00, 8'h00, 8'h00, 8'hA3);
        push_frame(8'hA3, 8'h00, 8'h00, 8'h00, 8'hA3);
        @(negedge clock);
        drive_msg(ARE_YOU_THERE, 9'h0, 4'h0, 4'h0, 1'b0);
        bus.send = 1'b1;
        @(posedge clock);
        fork
            capture(2*FRAME_CYC + 12);
            begin
                repeat (FRAME_CYC + 10) @(negedge clock);
                bus.send = 1'b0;
            end
        join
        for (int f = 0; f < 2; f++) begin
            for (int j = 0; j < 5; j++) begin
                e = exp_q.pop_front();
                of = bits_at(f*(FRAME_CYC + 2), j, 1'b0);
                ol = bits_at(f*(FRAME_CYC + 2), j, 1'b1);
                n_checks++;
                if (of !== {1'b1, e, 1'b0} || ol !== {1'b1, e, 1'b0})
                    $display("FAIL b2b_frame%0d_byte%0d: got first=%b last=%b expected %b", f, j, of, ol, {1'b1, e, 1'b0});
                else n_pass++;
            end
        end
        // Between frames: one done cycle, one ready cycle, then the next start bit.
        n_checks++;
        if (tx_log[FRAME_CYC+1] !== 1'b1 || tx_log[FRAME_CYC+2] !== 1'b1 || tx_log[FRAME_CYC+3] !== 1'b0 ||
            done_log[FRAME_CYC+1] !== 1'b1 || ready_log[FRAME_CYC+2] !== 1'b1)
            $display("FAIL b2b_gap: got tx=%b%b%b done=%b ready=%b expected tx=110 done=1 ready=1",
                     tx_log[FRAME_CYC+1], tx_log[FRAME_CYC+2], tx_log[FRAME_CYC+3], done_log[FRAME_CYC+1], ready_log[FRAME_CYC+2]);
        else n_pass++;
        ndone = 0;
        nbusy = 0;
        for (int i = 1; i <= 2*FRAME_CYC + 12; i++) if (done_log[i] === 1'b1) ndone++;
        for (int i = 2*FRAME_CYC + 3; i <= 2*FRAME_CYC + 12; i++) if (tx_log[i] !== 1'b1) nbusy++;
        n_checks++;
        if (ndone != 2 || nbusy != 0 || done_log[2*FRAME_CYC + 3] !== 1'b1)
            $display("FAIL b2b_end: got done=%0d low_cycles=%0d done@end=%b expected 2 0 1", ndone, nbusy, done_log[2*FRAME_CYC + 3]);
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] e;
        logic [9:0] of, ol;
        send_one(BALL, 9'h12C, 4'd5, 4'd3, 1'b1);
        capture(23*CPB + 2);
        n_checks++;
        if (tx_log[23*CPB + 2] !== 1'b0) $display("FAIL rstmid_pre: got tx=%b expected 0", tx_log[23*CPB + 2]);
        else n_pass++;
        #2 reset_L = 1'b0;
        #1;
        n_checks++;
        if (tx !== 1'b1 || bus.ready !== 1'b1)
            $display("FAIL rstmid_async: got tx=%b ready=%b expected 1 1", tx, bus.ready);
        else n_pass++;
        repeat (2) @(negedge clock);
        reset_L = 1'b1;
        @(negedge clock);
        n_checks++;
        if (tx !== 1'b1 || bus.ready !== 1'b1 || bus.done !== 1'b0)
            $display("FAIL rstmid_release: got tx=%b ready=%b done=%b expected 1 1 0", tx, bus.ready, bus.done);
        else n_pass++;
        push_frame(8'hA4, 8'h00, 8'h00, 8'h00, 8'hA4);
        send_one(I_AM_HERE, 9'h1AB, 4'd7, 4'd9, 1'b1);
        capture(FRAME_CYC + 4);
        for (int j = 0; j < 5; j++) begin
            e = exp_q.pop_front();
            of = bits_at(0, j, 1'b0);
            ol = bits_at(0, j, 1'b1);
            n_checks++;
            if (of !== {1'b1, e, 1'b0} || ol !== {1'b1, e, 1'b0})
                $display("FAIL rstmid_byte%0d: got first=%b last=%b expected %b", j, of, ol, {1'b1, e, 1'b0});
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_ball();
        test_new_game();
        test_invalid();
        test_mid_frame();
        test_back_to_back();
        test_reset_mid_frame();
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_leftover: got %0d bytes expected 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
